// File: rtl/instruction_fetch.sv
// instruction_fetch: PC generator and 2-entry fetch buffer in front of the
// instruction BRAM read port. It issues word addresses, captures the BRAM
// data one cycle later and delivers {pc, instr, fault} to decode through a
// valid/ready interface. It also handles redirects and address faults.
//
// Ports:
//   clk, rst_n      core clock, asynchronous active-low reset
//   cpu_run         fetch enable (0 = issue no new fetches)
//   imem_addr       BRAM word address, always fetch_pc[ADDR_W+1:2]
//   imem_rdata      BRAM read data, valid the cycle after the address
//   redirect_valid  replace the fetch stream with redirect_pc
//   redirect_pc     new fetch PC
//   out_valid/out_ready/out_pc/out_instr/out_fault  head entry to decode
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic              out_fault
);

  localparam int unsigned PC_W = 32;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            fault;
  } entry_t;

  entry_t          r_e0;
  entry_t          r_e1;
  entry_t          w_e0_nxt;
  entry_t          w_e1_nxt;
  entry_t          w_cap;
  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] w_fetch_pc_nxt;
  logic [PC_W-1:0] r_inflight_pc;
  logic [PC_W-1:0] w_inflight_pc_nxt;
  logic            r_inflight;
  logic            w_inflight_nxt;
  logic            r_halted;
  logic            w_halted_nxt;
  logic            w_pop;
  logic            w_space;
  logic            w_issue;
  logic [1:0]      w_occ;

  // Misaligned or beyond the BRAM word range.
  function automatic logic pc_fault(input logic [PC_W-1:0] pc);
    return (pc[1:0] != 2'b00) || (pc[PC_W-1:ADDR_W+2] != '0);
  endfunction

  // Next-state: buffer shift/capture, issue decision, redirect flush.
  always_comb begin
    w_pop   = r_e0.valid & out_ready;
    // The in-flight fetch already owns a buffer slot, so it counts as occupancy.
    w_occ   = 2'(r_e0.valid) + 2'(r_e1.valid) + 2'(r_inflight);
    w_space = (w_occ - 2'(w_pop)) < 2'd2;
    w_issue = cpu_run & ~r_halted & ~redirect_valid & w_space;

    w_cap.valid = 1'b1;
    w_cap.pc    = r_inflight_pc;
    w_cap.instr = imem_rdata;
    w_cap.fault = pc_fault(r_inflight_pc);

    w_e0_nxt          = w_pop ? r_e1 : r_e0;
    w_e1_nxt          = w_pop ? entry_t'('0) : r_e1;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_inflight_pc_nxt = r_inflight_pc;
    w_inflight_nxt    = 1'b0;
    w_halted_nxt      = r_halted;

    // The returning response goes to the first free slot after the pop.
    if (r_inflight) begin
      if (!w_e0_nxt.valid) begin
        w_e0_nxt = w_cap;
      end else begin
        w_e1_nxt = w_cap;
      end
    end

    if (redirect_valid) begin
      // Redirect beats any pop or capture in the same cycle.
      w_e0_nxt.valid = 1'b0;
      w_e1_nxt.valid = 1'b0;
      w_fetch_pc_nxt = redirect_pc;
      w_halted_nxt   = 1'b0;
    end else if (w_issue) begin
      w_inflight_nxt    = 1'b1;
      w_inflight_pc_nxt = r_fetch_pc;
      w_fetch_pc_nxt    = r_fetch_pc + PC_W'(4);
      if (pc_fault(r_fetch_pc)) begin
        w_halted_nxt = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_halted      <= 1'b0;
      r_e0          <= '0;
      r_e1          <= '0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_inflight_pc <= w_inflight_pc_nxt;
      r_inflight    <= w_inflight_nxt;
      r_halted      <= w_halted_nxt;
      r_e0          <= w_e0_nxt;
      r_e1          <= w_e1_nxt;
    end
  end

  // Outputs come straight from registers; nothing from imem_rdata leaks through.
  assign imem_addr = r_fetch_pc[ADDR_W+1:2];
  assign out_valid = r_e0.valid;
  assign out_pc    = r_e0.pc;
  assign out_instr = r_e0.instr;
  assign out_fault = r_e0.fault;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned ADDR_W   = 12;

  logic              clk;
  logic              rst_n;
  logic              cpu_run;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_instr;
  logic              out_fault;

  instruction_fetch #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_run(cpu_run), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_fault(out_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: word k holds 0x1000_0000 + k, one-cycle registered read.
  always @(posedge clk) imem_rdata <= 32'h1000_0000 + 32'(imem_addr);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules: instruction is the word the PC aliases onto.
  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return 32'h1000_0000 + {20'h0, pc[13:2]};
  endfunction

  function automatic logic fault_of(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc[31:14] != 18'h0);
  endfunction

  // Transaction-level scoreboard: accepted entries form a sequential PC stream
  // restarting at each redirect/reset and ending after the first faulting PC.
  logic [31:0] exp_pc;
  logic        exp_done;
  int          pops = 0;
  logic        p_live, p_valid, p_ready, p_redir;
  logic [31:0] p_pc, p_instr;

  initial begin
    exp_pc = RESET_PC; exp_done = 1'b0; p_live = 1'b0;
    p_valid = 1'b0; p_ready = 1'b0; p_redir = 1'b0; p_pc = '0; p_instr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_pc = RESET_PC; exp_done = 1'b0; p_live = 1'b0;
      end else begin
        if (p_live && p_valid && !p_ready && !p_redir) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_pc", out_pc, p_pc);
          chk("hold_instr", out_instr, p_instr);
        end
        if (redirect_valid) begin
          exp_pc = redirect_pc; exp_done = 1'b0;
        end else if (out_valid && out_ready) begin
          pops++;
          chk("stream_after_fault", 32'(exp_done), 32'd0);
          chk("stream_pc", out_pc, exp_pc);
          chk("stream_instr", out_instr, word_of(exp_pc));
          chk("stream_fault", 32'(out_fault), 32'(fault_of(exp_pc)));
          if (fault_of(exp_pc)) exp_done = 1'b1;
          exp_pc = exp_pc + 32'd4;
        end
        p_live = 1'b1; p_valid = out_valid; p_ready = out_ready;
        p_redir = redirect_valid; p_pc = out_pc; p_instr = out_instr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int n;
    int pops_before;
    int r;
    rst_n = 1'b0; cpu_run = 1'b0; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) tick();

    // Reset values
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_pc", out_pc, 32'd0);
    chk("reset_instr", out_instr, 32'd0);
    chk("reset_fault", 32'(out_fault), 32'd0);
    chk("reset_addr", 32'(imem_addr), (RESET_PC >> 2) & 32'hFFF);
    rst_n = 1'b1;
    tick();
    chk("idle_no_issue", 32'(imem_addr), (RESET_PC >> 2) & 32'hFFF);

    // Latency and streaming
    cpu_run = 1'b1;
    tick();
    chk("lat_t1_valid", 32'(out_valid), 32'd0);
    chk("lat_t1_addr", 32'(imem_addr), 32'd1);
    tick();
    chk("lat_t2_valid", 32'(out_valid), 32'd1);
    chk("lat_t2_pc", out_pc, 32'h0);
    chk("lat_t2_instr", out_instr, 32'h1000_0000);
    tick();
    chk("stream_pc4", out_pc, 32'h4);
    tick();
    chk("stream_pc8", out_pc, 32'h8);

    // Back-pressure: head held
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_pc", out_pc, 32'h8);
    end
    out_ready = 1'b1;
    tick();

    // Redirect with buffered and in-flight fetches, pop in the same cycle
    redirect_to(32'h100);
    chk("redir_r1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("redir_r2_valid", 32'(out_valid), 32'd0);
    tick();
    chk("redir_r3_valid", 32'(out_valid), 32'd1);
    chk("redir_r3_pc", out_pc, 32'h100);
    chk("redir_r3_instr", out_instr, 32'h1000_0040);
    repeat (2) tick();

    // Misaligned redirect faults and halts
    redirect_to(32'h102);
    repeat (2) tick();
    chk("mis_valid", 32'(out_valid), 32'd1);
    chk("mis_pc", out_pc, 32'h102);
    chk("mis_instr", out_instr, 32'h1000_0040);
    chk("mis_fault", 32'(out_fault), 32'd1);
    repeat (6) begin
      tick();
      chk("mis_halted", 32'(out_valid), 32'd0);
    end
    redirect_to(32'h200);
    repeat (2) tick();
    chk("resume_valid", 32'(out_valid), 32'd1);
    chk("resume_pc", out_pc, 32'h200);
    chk("resume_fault", 32'(out_fault), 32'd0);

    // Running off the end of the BRAM
    redirect_to(32'h3FF0);
    n = 0;
    while (!(out_valid && out_pc == 32'h4000) && n < 20) begin
      tick();
      n++;
    end
    chk("oob_reached", 32'(n < 20), 32'd1);
    chk("oob_instr", out_instr, 32'h1000_0000);
    chk("oob_fault", 32'(out_fault), 32'd1);
    repeat (5) begin
      tick();
      chk("oob_halted", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset mid-stream
    redirect_to(32'h500);
    repeat (2) tick();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_addr", 32'(imem_addr), (RESET_PC >> 2) & 32'hFFF);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_t1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_pc", out_pc, RESET_PC);

    // Randomized traffic against the scoreboard
    pops_before = pops;
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom % 10) < 7;
      cpu_run   = ($urandom % 10) < 9;
      redirect_valid = ($urandom % 40) == 0;
      r = int'($urandom % 8);
      if (r < 5)       redirect_pc = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
      else if (r == 5) redirect_pc = 32'h3FE0;
      else if (r == 6) redirect_pc = {18'h0, 12'($urandom_range(0, 4095)), 2'($urandom_range(1, 3))};
      else             redirect_pc = $urandom;
      tick();
    end
    redirect_valid = 1'b0;
    chk("random_progress", 32'(pops - pops_before > 300), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
